// File: rtl/scan_decoder_if.sv
// Select handshake and decoded-output bundle for scan_decoder.
// master drives en/mode/select; slave (the decoder) returns ready and the decoded lines.
interface scan_decoder_if #(
    parameter int N = 3
) ();
    logic             en;
    logic             mode;
    logic             sel_valid;
    logic [N-1:0]     sel;
    logic             sel_ready;
    logic [2**N-1:0]  D;
    logic [N-1:0]     cur_idx;
    logic             wrap;

    // Handshake: a select word transfers on any cycle where sel_valid and sel_ready are both 1;
    // sel_valid may be held across cycles and every overlapping cycle is a separate transfer.
    modport master (
        output en, mode, sel_valid, sel,
        input  sel_ready, D, cur_idx, wrap
    );

    modport slave (
        input  en, mode, sel_valid, sel,
        output sel_ready, D, cur_idx, wrap
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2**N one-hot decoder with a DIRECT (handshaked select) mode and a
// SCAN mode that steps through every output, each held for DWELL cycles.
module scan_decoder #(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic         clk,
    input  logic         rst,
    scan_decoder_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int W  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
    localparam logic [W-1:0]  INV  = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [N-1:0]    idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            wrap_q, wrap_n;
    logic [W-1:0]    d_q, dec_n;
    logic            ready;
    logic            xfer;

    assign ready         = bus.en & ~bus.mode & ~rst;
    assign xfer          = bus.sel_valid & ready;
    assign bus.sel_ready = ready;
    assign bus.D         = d_q;
    assign bus.cur_idx   = idx;
    assign bus.wrap      = wrap_q;
    assign dbg_state     = state;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        wrap_n  = 1'b0;
        if (!bus.en) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else if (!bus.mode) begin
            if (xfer) begin
                state_n = HOLD;
                idx_n   = bus.sel;
                cnt_n   = '0;
            end else if (state == SCAN) begin
                // Leaving SCAN without a new select drops back to no active output.
                state_n = IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        end else begin
            if (state != SCAN) begin
                state_n = SCAN;
                idx_n   = '0;
                cnt_n   = '0;
            end else if (cnt == LAST) begin
                cnt_n  = '0;
                idx_n  = idx + N'(1);
                wrap_n = (idx == {N{1'b1}});
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end
    end

    always_comb begin
        dec_n = '0;
        if (state_n != IDLE) dec_n[idx_n] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            wrap_q <= 1'b0;
            d_q    <= INV;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            wrap_q <= wrap_n;
            d_q    <= dec_n ^ INV;
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: default instance (DWELL=4, active-high) and an
// ACTIVE_LOW=1, DWELL=1 instance.
module tb_scan_decoder;
    logic clk;
    logic rst_a, rst_b;
    logic [1:0] st_a, st_b;
    int total = 0;
    int bad   = 0;

    scan_decoder_if #(.N(3)) ia ();
    scan_decoder_if #(.N(3)) ib ();

    scan_decoder #(.N(3), .DWELL(4), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ia), .dbg_state(st_a)
    );
    scan_decoder #(.N(3), .DWELL(1), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ib), .dbg_state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] one;
        int idx_e;
        one = 8'h01;
        rst_a = 1'b1; ia.en = 1'b1; ia.mode = 1'b1; ia.sel_valid = 1'b0; ia.sel = 3'd0;
        rst_b = 1'b1; ib.en = 1'b1; ib.mode = 1'b1; ib.sel_valid = 1'b0; ib.sel = 3'd0;

        // Reset
        tick(); tick();
        chk("rst_d", ia.D, 8'h00);
        chk("rst_idx", {5'd0, ia.cur_idx}, 8'd0);
        chk("rst_wrap", {7'd0, ia.wrap}, 8'd0);
        chk("rst_ready", {7'd0, ia.sel_ready}, 8'd0);
        chk("rst_state", {6'd0, st_a}, 8'd0);
        chk("rst_d_al", ib.D, 8'hFF);

        // DIRECT back-to-back transfers
        rst_a = 1'b0; ia.mode = 1'b0; ia.sel_valid = 1'b1; ia.sel = 3'd5;
        #1;
        chk("dir_ready", {7'd0, ia.sel_ready}, 8'd1);
        tick();
        chk("dir_d5", ia.D, 8'h20);
        chk("dir_idx5", {5'd0, ia.cur_idx}, 8'd5);
        chk("dir_hold_state", {6'd0, st_a}, 8'd1);
        ia.sel = 3'd2;
        tick();
        chk("dir_d2", ia.D, 8'h04);
        ia.sel_valid = 1'b0;
        tick();
        chk("dir_keep1", ia.D, 8'h04);
        tick();
        chk("dir_keep2", ia.D, 8'h04);
        chk("dir_keep_idx", {5'd0, ia.cur_idx}, 8'd2);

        // SCAN with sel_valid asserted (ignored)
        ia.mode = 1'b1; ia.sel_valid = 1'b1; ia.sel = 3'd6;
        #1;
        chk("scan_ready", {7'd0, ia.sel_ready}, 8'd0);
        for (int k = 1; k <= 45; k++) begin
            tick();
            idx_e = ((k - 1) / 4) % 8;
            chk($sformatf("scan_d_k%0d", k), ia.D, one << idx_e);
            chk($sformatf("scan_wrap_k%0d", k), {7'd0, ia.wrap}, (k == 33) ? 8'd1 : 8'd0);
        end
        chk("scan_at_08_idx", {5'd0, ia.cur_idx}, 8'd3);

        // Mode switch with transfer goes straight to HOLD
        ia.mode = 1'b0; ia.sel_valid = 1'b1; ia.sel = 3'd1;
        tick();
        chk("sw_d", ia.D, 8'h02);
        chk("sw_state", {6'd0, st_a}, 8'd1);

        // Mode switch without transfer drops to IDLE
        ia.mode = 1'b1; ia.sel_valid = 1'b0;
        tick();
        chk("sw2_scan_d", ia.D, 8'h01);
        ia.mode = 1'b0;
        tick();
        chk("sw2_idle_d", ia.D, 8'h00);
        chk("sw2_idle_state", {6'd0, st_a}, 8'd0);

        // en=0 mid-scan
        ia.mode = 1'b1;
        tick(); tick();
        chk("en_scan_d", ia.D, 8'h01);
        ia.en = 1'b0;
        tick();
        chk("en_off_d", ia.D, 8'h00);
        chk("en_off_state", {6'd0, st_a}, 8'd0);

        // rst in HOLD with an in-flight select
        ia.en = 1'b1; ia.mode = 1'b0; ia.sel_valid = 1'b1; ia.sel = 3'd7;
        tick();
        chk("hold7_d", ia.D, 8'h80);
        rst_a = 1'b1; ia.sel = 3'd3;
        tick();
        chk("rst_hold_d", ia.D, 8'h00);
        chk("rst_hold_idx", {5'd0, ia.cur_idx}, 8'd0);
        rst_a = 1'b0; ia.sel_valid = 1'b0;

        // ACTIVE_LOW=1, DWELL=1 scanning
        rst_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            idx_e = (k - 1) % 8;
            chk($sformatf("al_d_k%0d", k), ib.D, ~(one << idx_e));
            chk($sformatf("al_wrap_k%0d", k), {7'd0, ib.wrap}, (k == 9) ? 8'd1 : 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
